// File: rtl/rd_port_sched.sv
// Four-port round-robin read-burst scheduler.
// Keeps one command outstanding at a time and tracks per-port frame progress.
module rd_port_sched #(
  parameter int         CTRL_ADDR_WIDTH = 28,
  parameter int         ADDR_STEP       = 128,
  parameter logic [3:0] BURST_LEN       = 4'd15
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [3:0]                   port_enable,
  input  logic [3:0]                   port_req,
  input  logic [4*CTRL_ADDR_WIDTH-1:0] port_base_addr,
  input  logic [63:0]                  port_frame_bursts,
  input  logic [3:0]                   port_frame_start,
  output logic                         rd_en,
  output logic [CTRL_ADDR_WIDTH-1:0]   rd_addr,
  output logic [3:0]                   rd_id,
  output logic [3:0]                   rd_len,
  input  logic                         rd_done_p,
  output logic [3:0]                   grant,
  output logic [1:0]                   grant_id,
  output logic [3:0]                   port_frame_done,
  output logic                         busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t                     state;
  logic [15:0]                cnt [4];
  logic [CTRL_ADDR_WIDTH-1:0] off [4];
  logic [1:0]                 last_grant;
  logic                       stale;

  logic [3:0]  elig;
  logic [3:0]  rot;
  logic [1:0]  start;
  logic [1:0]  pick;
  logic [1:0]  winner;
  logic        any_elig;
  logic [15:0] cnt_next;
  logic        restart_g;

  // Eligibility and round-robin pick: rotate so the search origin sits at bit 0.
  always_comb begin
    start = last_grant + 2'd1;
    for (int n = 0; n < 4; n++) begin
      elig[n] = port_enable[n] & port_req[n] &
                (cnt[n] < port_frame_bursts[n*16 +: 16]);
    end
    for (int k = 0; k < 4; k++) begin
      rot[k] = elig[start + 2'(k)];
    end
    casez (rot)
      4'b???1: pick = 2'd0;
      4'b??10: pick = 2'd1;
      4'b?100: pick = 2'd2;
      4'b1000: pick = 2'd3;
      default: pick = 2'd0;
    endcase
    winner    = start + pick;
    any_elig  = |elig;
    cnt_next  = cnt[grant_id] + 16'd1;
    restart_g = port_frame_start[grant_id];
  end

  // Scheduler FSM, command registers and per-port frame counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= IDLE;
      rd_en           <= 1'b0;
      rd_addr         <= '0;
      rd_id           <= 4'd0;
      rd_len          <= BURST_LEN;
      grant           <= 4'd0;
      grant_id        <= 2'd0;
      port_frame_done <= 4'd0;
      busy            <= 1'b0;
      last_grant      <= 2'd3;
      stale           <= 1'b0;
      for (int n = 0; n < 4; n++) begin
        cnt[n] <= 16'd0;
        off[n] <= '0;
      end
    end else begin
      rd_en           <= 1'b0;
      port_frame_done <= 4'd0;
      case (state)
        IDLE: begin
          stale <= 1'b0;
          if (any_elig) begin
            state      <= ISSUE;
            rd_en      <= 1'b1;
            busy       <= 1'b1;
            grant      <= 4'b0001 << winner;
            grant_id   <= winner;
            last_grant <= winner;
            rd_addr    <= port_base_addr[int'(winner)*CTRL_ADDR_WIDTH +: CTRL_ADDR_WIDTH]
                          + off[winner];
            rd_id      <= {2'b00, winner};
            rd_len     <= BURST_LEN;
          end
        end
        ISSUE: begin
          state <= WAIT;
          if (restart_g) stale <= 1'b1;
        end
        WAIT: begin
          if (restart_g) stale <= 1'b1;
          if (rd_done_p) begin
            state <= IDLE;
            busy  <= 1'b0;
            grant <= 4'd0;
            // A restart seen during this burst means its completion belongs to the old frame.
            if (!stale && !restart_g) begin
              cnt[grant_id] <= cnt_next;
              off[grant_id] <= off[grant_id] + CTRL_ADDR_WIDTH'(ADDR_STEP);
              if (cnt_next == port_frame_bursts[int'(grant_id)*16 +: 16]) begin
                port_frame_done[grant_id] <= 1'b1;
              end
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          grant <= 4'd0;
        end
      endcase
      for (int n = 0; n < 4; n++) begin
        if (port_frame_start[n]) begin
          cnt[n] <= 16'd0;
          off[n] <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_rd_port_sched.sv
// Directed self-checking bench for rd_port_sched.
module tb_rd_port_sched;
  localparam int W = 28;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [3:0]     port_enable, port_req, port_frame_start;
  logic [4*W-1:0] port_base_addr;
  logic [63:0]    port_frame_bursts;
  logic           rd_done_p;
  logic           rd_en;
  logic [W-1:0]   rd_addr;
  logic [3:0]     rd_id, rd_len, grant, port_frame_done;
  logic [1:0]     grant_id;
  logic           busy;

  logic [W-1:0]   base [4];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rd_port_sched #(.CTRL_ADDR_WIDTH(W), .ADDR_STEP(128), .BURST_LEN(4'd15)) dut (
    .clk(clk), .rst_n(rst_n), .port_enable(port_enable), .port_req(port_req),
    .port_base_addr(port_base_addr), .port_frame_bursts(port_frame_bursts),
    .port_frame_start(port_frame_start), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_id(rd_id), .rd_len(rd_len), .rd_done_p(rd_done_p), .grant(grant),
    .grant_id(grant_id), .port_frame_done(port_frame_done), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic load_bases();
    for (int n = 0; n < 4; n++) port_base_addr[n*W +: W] = base[n];
  endtask

  task automatic wait_rd_en(input string tag);
    int n = 0;
    while (rd_en !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_issue"}, 32'(rd_en), 32'd1);
  endtask

  task automatic finish_burst(input int dly);
    repeat (dly) @(negedge clk);
    rd_done_p = 1'b1;
    @(negedge clk);
    rd_done_p = 1'b0;
  endtask

  task automatic pulse_start(input logic [3:0] m);
    port_frame_start = m;
    @(negedge clk);
    port_frame_start = 4'd0;
  endtask

  task automatic count_quiet(input string tag, input int cycles);
    int seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (rd_en === 1'b1) seen++;
    end
    chk(tag, 32'(seen), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    port_enable = 4'd0;
    port_req = 4'd0;
    port_frame_start = 4'd0;
    port_frame_bursts = 64'd0;
    rd_done_p = 1'b0;
    base[0] = 28'h1000000;
    base[1] = 28'h0000100;
    base[2] = 28'h2000000;
    base[3] = 28'h3000000;
    load_bases();
    repeat (3) @(negedge clk);
    chk("rst_rd_en", 32'(rd_en), 32'd0);
    chk("rst_rd_addr", 32'(rd_addr), 32'd0);
    chk("rst_rd_id", 32'(rd_id), 32'd0);
    chk("rst_rd_len", 32'(rd_len), 32'd15);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_fdone", 32'(port_frame_done), 32'd0);
    rst_n = 1'b1;

    // Single port 1, three-burst frame.
    port_frame_bursts[16 +: 16] = 16'd3;
    port_enable = 4'b0010;
    port_req = 4'b0010;
    for (int b = 0; b < 3; b++) begin
      wait_rd_en("p1");
      chk("p1_addr", 32'(rd_addr), 32'h100 + 32'(b) * 32'h80);
      chk("p1_id", 32'(rd_id), 32'd1);
      chk("p1_grant", 32'(grant), 32'b0010);
      chk("p1_len", 32'(rd_len), 32'd15);
      finish_burst(4);
      chk("p1_grant_clr", 32'(grant), 32'd0);
      chk("p1_busy_clr", 32'(busy), 32'd0);
      chk("p1_fdone", 32'(port_frame_done), (b == 2) ? 32'b0010 : 32'd0);
      chk("p1_gap", 32'(rd_en), 32'd0);
    end
    count_quiet("p1_quiet", 10);
    pulse_start(4'b0010);
    wait_rd_en("p1_restart");
    chk("p1_restart_addr", 32'(rd_addr), 32'h100);
    @(negedge clk);
    port_enable = 4'd0;
    port_req = 4'd0;
    finish_burst(2);
    chk("p1_drop_busy", 32'(busy), 32'd0);
    chk("p1_drop_grant", 32'(grant), 32'd0);
    count_quiet("p1_drop_quiet", 5);

    // Round robin over all four ports, starting after port 1.
    pulse_start(4'hF);
    port_frame_bursts = {16'd100, 16'd100, 16'd100, 16'd100};
    port_enable = 4'hF;
    port_req = 4'hF;
    begin
      logic [1:0] order [8];
      order = '{2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
      for (int i = 0; i < 8; i++) begin
        wait_rd_en("rr");
        chk("rr_gid", 32'(grant_id), 32'(order[i]));
        chk("rr_grant", 32'(grant), 32'd1 << order[i]);
        chk("rr_addr", 32'(rd_addr), 32'(base[order[i]]) + 32'(i / 4) * 32'h80);
        finish_burst(2);
      end
    end

    // Port 2 restart coinciding with completion of its fifth burst.
    port_enable = 4'b0100;
    port_req = 4'b0100;
    wait_rd_en("p2a");
    chk("p2a_addr", 32'(rd_addr), 32'h2000100);
    finish_burst(2);
    wait_rd_en("p2b");
    chk("p2b_addr", 32'(rd_addr), 32'h2000180);
    finish_burst(2);
    wait_rd_en("p2c");
    chk("p2c_addr", 32'(rd_addr), 32'h2000200);
    repeat (2) @(negedge clk);
    rd_done_p = 1'b1;
    port_frame_start = 4'b0100;
    @(negedge clk);
    rd_done_p = 1'b0;
    port_frame_start = 4'd0;
    chk("p2_fs_fdone", 32'(port_frame_done), 32'd0);
    wait_rd_en("p2d");
    chk("p2d_addr", 32'(rd_addr), 32'h2000000);
    finish_burst(2);
    port_enable = 4'd0;
    port_req = 4'd0;

    // Address wrap on port 0, done ignored in ISSUE, restart during WAIT.
    base[0] = 28'hFFFFF80;
    load_bases();
    pulse_start(4'b0001);
    port_enable = 4'b0001;
    port_req = 4'b0001;
    wait_rd_en("w1");
    chk("w1_addr", 32'(rd_addr), 32'hFFFFF80);
    rd_done_p = 1'b1;
    @(negedge clk);
    rd_done_p = 1'b0;
    chk("issue_done_busy", 32'(busy), 32'd1);
    chk("issue_done_grant", 32'(grant), 32'b0001);
    finish_burst(2);
    wait_rd_en("w2");
    chk("w2_addr", 32'(rd_addr), 32'h0000000);
    finish_burst(2);
    wait_rd_en("w3");
    chk("w3_addr", 32'(rd_addr), 32'h0000080);
    @(negedge clk);
    pulse_start(4'b0001);
    finish_burst(1);
    chk("stale_fdone", 32'(port_frame_done), 32'd0);
    wait_rd_en("w4");
    chk("stale_addr", 32'(rd_addr), 32'hFFFFF80);
    finish_burst(2);
    port_enable = 4'd0;
    port_req = 4'd0;

    // Reset in the middle of a port-3 burst.
    port_enable = 4'b1001;
    port_req = 4'b1001;
    wait_rd_en("r3");
    chk("r3_gid", 32'(grant_id), 32'd3);
    chk("r3_addr", 32'(rd_addr), 32'h3000100);
    @(negedge clk);
    rst_n = 1'b0;
    port_enable = 4'd0;
    port_req = 4'd0;
    repeat (2) @(negedge clk);
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_grant", 32'(grant), 32'd0);
    chk("mrst_gid", 32'(grant_id), 32'd0);
    chk("mrst_rd_en", 32'(rd_en), 32'd0);
    rst_n = 1'b1;
    rd_done_p = 1'b1;
    @(negedge clk);
    rd_done_p = 1'b0;
    chk("late_done_busy", 32'(busy), 32'd0);
    chk("late_done_grant", 32'(grant), 32'd0);
    chk("late_done_fdone", 32'(port_frame_done), 32'd0);
    port_enable = 4'b1001;
    port_req = 4'b1001;
    wait_rd_en("post_rst");
    chk("post_rst_gid", 32'(grant_id), 32'd0);
    chk("post_rst_addr", 32'(rd_addr), 32'hFFFFF80);
    finish_burst(2);
    port_enable = 4'b1000;
    port_req = 4'b1000;
    wait_rd_en("post_rst_p3");
    chk("post_rst_p3_addr", 32'(rd_addr), 32'h3000000);
    finish_burst(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
